dmem_port_arbiter: RTL and testbench

- Shares one single-port, 256-word data memory between two requesters: port 0 is the CPU load/store stage, port 1 is the debug/program-loader port.
- Accepts one request at a time using a valid/ready handshake.
- Arbitrates round-robin between the two ports.
- Drives single-cycle read/write strobes to the memory, then returns a response pulse on the granted port.
- Sits between the pipeline's MEM stage and the data memory array.

---
 rtl/dmem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter
//  Purpose  : Round-robin arbiter sharing one single-port data memory between
//             the CPU MEM stage (port 0) and the debug/loader port (port 1).
//  Revision : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic          p0_req_we,
  input  logic [31:0]   p0_req_addr,
  input  logic [DW-1:0] p0_req_wdata,
  output logic          p0_rsp_valid,
  output logic [DW-1:0] p0_rsp_rdata,
  output logic          p0_rsp_err,
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic          p1_req_we,
  input  logic [31:0]   p1_req_addr,
  input  logic [DW-1:0] p1_req_wdata,
  output logic          p1_rsp_valid,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic          p1_rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_RESP  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic          r_last_grant;
  logic          r_port;
  logic          r_we;
  logic          w_any;
  logic          w_grant;
  logic          w_accept;
  logic          w_err;
  logic          w_req_we;
  logic [31:0]   w_req_addr;
  logic [DW-1:0] w_req_wdata;
  logic          w_enter_resp;
  logic          w_rsp_port;
  logic          w_rsp_err;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    w_any       = p0_req_valid | p1_req_valid;
    w_grant     = (p0_req_valid && p1_req_valid) ? ~r_last_grant : p1_req_valid;
    w_req_we    = w_grant ? p1_req_we    : p0_req_we;
    w_req_addr  = w_grant ? p1_req_addr  : p0_req_addr;
    w_req_wdata = w_grant ? p1_req_wdata : p0_req_wdata;
    w_err       = (w_req_addr[1:0] != 2'b00) || ((w_req_addr >> (AW + 2)) != 32'd0);
    w_accept    = (r_state == c_ST_IDLE) && w_any && !rst;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_accept) w_next_state = w_err ? c_ST_RESP : c_ST_ISSUE;
      c_ST_ISSUE: w_next_state = r_we ? c_ST_RESP : c_ST_WAIT;
      c_ST_WAIT:  w_next_state = c_ST_RESP;
      default:    w_next_state = c_ST_IDLE;
    endcase
  end

  // Errors go straight from IDLE to RESP, so only that path can carry err.
  always_comb begin
    w_enter_resp = (w_next_state == c_ST_RESP) && (r_state != c_ST_RESP);
    w_rsp_port   = (r_state == c_ST_IDLE) ? w_grant : r_port;
    w_rsp_err    = (r_state == c_ST_IDLE) && w_err;
  end

  assign p0_req_ready = w_accept && !w_grant;
  assign p1_req_ready = w_accept &&  w_grant;
  assign busy         = (r_state != c_ST_IDLE);
  assign mem_read     = (r_state == c_ST_ISSUE) && !r_we;
  assign mem_write    = (r_state == c_ST_ISSUE) &&  r_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_ST_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      p0_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p0_rsp_err   <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p1_rsp_rdata <= '0;
      p1_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_port       <= w_grant;
        r_we         <= w_req_we;
        // Erroring requests never touch the memory-facing registers.
        if (!w_err) begin
          mem_addr  <= w_req_addr[AW+1:2];
          mem_wdata <= w_req_wdata;
        end
      end
      p0_rsp_valid <= w_enter_resp && !w_rsp_port;
      p0_rsp_err   <= w_enter_resp && !w_rsp_port && w_rsp_err;
      p0_rsp_rdata <= ((r_state == c_ST_WAIT) && !r_port) ? mem_rdata : '0;
      p1_rsp_valid <= w_enter_resp &&  w_rsp_port;
      p1_rsp_err   <= w_enter_resp &&  w_rsp_port && w_rsp_err;
      p1_rsp_rdata <= ((r_state == c_ST_WAIT) &&  r_port) ? mem_rdata : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_port_arbiter
//  Purpose  : Directed plus randomized bench for dmem_port_arbiter against a
//             transaction-timing reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
  logic        p0_rsp_valid, p0_rsp_err;
  logic        p1_req_valid, p1_req_ready, p1_req_we;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
  logic        p1_rsp_valid, p1_rsp_err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy;

  dmem_port_arbiter #(.AW(8), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with one-cycle read latency.
  logic [31:0] tb_mem [256];
  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= tb_mem[mem_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one transaction at a time, timing from fixed latencies.
  int          cyc = 0;
  int          free_at, st_cyc, rsp_cyc;
  logic        st_we, rsp_port, rsp_err, last_grant;
  logic [7:0]  st_addr;
  logic [31:0] st_wdata, rsp_data;
  logic [31:0] mdl_mem [256];
  int          n_acc = 0, n_rsp = 0;
  logic        acc_port_q[$];
  int          acc_cyc_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_at = cyc; st_cyc = -1; rsp_cyc = -1; last_grant = 1'b1;
    st_we = 1'b0; st_addr = 8'd0; st_wdata = 32'd0;
    rsp_port = 1'b0; rsp_err = 1'b0; rsp_data = 32'd0;
  endtask

  task automatic model_accept(input logic g);
    logic [31:0] a;
    logic        we, err;
    a   = g ? p1_req_addr : p0_req_addr;
    we  = g ? p1_req_we   : p0_req_we;
    err = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    last_grant = g; n_acc++;
    acc_port_q.push_back(g); acc_cyc_q.push_back(cyc);
    rsp_port = g; rsp_err = err; rsp_data = 32'd0;
    if (err) begin
      rsp_cyc = cyc + 1; free_at = cyc + 2;
    end else begin
      st_cyc = cyc + 1; st_we = we; st_addr = a[9:2];
      st_wdata = g ? p1_req_wdata : p0_req_wdata;
      if (we) begin
        mdl_mem[a[9:2]] = st_wdata;
        rsp_cyc = cyc + 2; free_at = cyc + 3;
      end else begin
        rsp_data = mdl_mem[a[9:2]];
        rsp_cyc = cyc + 3; free_at = cyc + 4;
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic run_cycle();
    logic idle, any, g, r0, r1;
    #1;
    idle = (cyc >= free_at);
    any  = p0_req_valid | p1_req_valid;
    g    = (p0_req_valid && p1_req_valid) ? ~last_grant : p1_req_valid;
    r0   = (cyc == rsp_cyc) && !rsp_port;
    r1   = (cyc == rsp_cyc) &&  rsp_port;
    chk("p0_ready", p0_req_ready, idle && any && !g);
    chk("p1_ready", p1_req_ready, idle && any &&  g);
    chk("busy", busy, !idle);
    chk("mem_read", mem_read, (cyc == st_cyc) && !st_we);
    chk("mem_write", mem_write, (cyc == st_cyc) && st_we);
    chk("strobe_excl", mem_read && mem_write, 0);
    chk("mem_addr", mem_addr, st_addr);
    chk("mem_wdata", mem_wdata, st_wdata);
    chk("p0_rsp_valid", p0_rsp_valid, r0);
    chk("p0_rsp_rdata", p0_rsp_rdata, r0 ? rsp_data : 32'd0);
    chk("p0_rsp_err", p0_rsp_err, r0 && rsp_err);
    chk("p1_rsp_valid", p1_rsp_valid, r1);
    chk("p1_rsp_rdata", p1_rsp_rdata, r1 ? rsp_data : 32'd0);
    chk("p1_rsp_err", p1_rsp_err, r1 && rsp_err);
    if (p0_rsp_valid) n_rsp++;
    if (p1_rsp_valid) n_rsp++;
    if (idle && any) model_accept(g);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cyc < free_at && k < 20) begin
      run_cycle();
      k++;
    end
    #1 chk("idle_timeout", busy, 0);
  endtask

  task automatic new_req(output logic we, output logic [31:0] addr, output logic [31:0] data);
    logic [31:0] rnd;
    int          kind;
    rnd  = $urandom;
    kind = $urandom_range(9, 0);
    we   = rnd[31];
    data = $urandom;
    addr = {22'd0, rnd[7:0], 2'b00};
    if (kind == 0) addr = addr | 32'($urandom_range(3, 1));
    else if (kind == 1) addr = addr | (32'h400 << $urandom_range(21, 0));
  endtask

  initial begin
    int base, sz, guard;
    rst = 1'b1;
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 32'd0; p0_req_wdata = 32'd0;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'd0; p1_req_wdata = 32'd0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_p0_ready", p0_req_ready, 0);
    chk("rst_p1_ready", p1_req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp", {p0_rsp_valid, p0_rsp_err, p1_rsp_valid, p1_rsp_err}, 0);
    chk("rst_rdata", {p0_rsp_rdata, p1_rsp_rdata}, 0);
    @(negedge clk);
    p0_req_valid = 1'b0; p1_req_valid = 1'b0; rst = 1'b0;
    model_reset();

    // Write then read on port 0.
    p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'h10; p0_req_wdata = 32'hDEADBEEF;
    run_cycle();
    p0_req_valid = 1'b0;
    #1 chk("wr_strobe", mem_write, 1);
    chk("wr_mem_addr", mem_addr, 8'd4);
    wait_idle();
    p0_req_valid = 1'b1; p0_req_we = 1'b0;
    run_cycle();
    p0_req_valid = 1'b0;
    run_cycle(); run_cycle();
    #1 chk("rd_deadbeef", p0_rsp_rdata, 32'hDEADBEEF);
    wait_idle();

    // Fill the whole memory so every later read has a known value.
    for (int i = 0; i < 256; i++) begin
      p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'(i) << 2; p0_req_wdata = $urandom;
      run_cycle();
      p0_req_valid = 1'b0;
      wait_idle();
    end

    // Port 1 errors: misaligned and out of range.
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'h13;
    run_cycle();
    p1_req_valid = 1'b0;
    #1 chk("err_misaligned", {p1_rsp_valid, p1_rsp_err}, 2'b11);
    wait_idle();
    p1_req_valid = 1'b1; p1_req_addr = 32'h400;
    run_cycle();
    p1_req_valid = 1'b0;
    #1 chk("err_range_rdata", p1_rsp_rdata, 0);
    wait_idle();

    // Port 1 streaming writes.
    base = acc_cyc_q.size();
    p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 32'h40; p1_req_wdata = 32'h1111_0000;
    guard = 0;
    while (acc_cyc_q.size() < base + 3 && guard < 30) begin
      sz = acc_cyc_q.size();
      run_cycle();
      if (acc_cyc_q.size() != sz) begin
        p1_req_addr = p1_req_addr + 32'd4; p1_req_wdata = p1_req_wdata + 32'd1;
      end
      guard++;
    end
    p1_req_valid = 1'b0;
    wait_idle();
    chk("stream_accepts", acc_cyc_q.size() - base, 3);
    chk("stream_gap1", acc_cyc_q[base+1] - acc_cyc_q[base], 3);
    chk("stream_gap2", acc_cyc_q[base+2] - acc_cyc_q[base+1], 3);

    // Reset while a read sits in WAIT.
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 32'h20;
    run_cycle();
    p0_req_valid = 1'b0;
    run_cycle();
    #1 chk("pre_abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_strobes", {mem_read, mem_write}, 0);
    chk("abort_rsp", {p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err}, 0);
    chk("abort_mem_addr", mem_addr, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_acc--;
    run_cycle(); run_cycle(); run_cycle();

    // Tie from reset: grants alternate starting with port 0.
    base = acc_port_q.size();
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 32'h8;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'h24;
    guard = 0;
    while (acc_port_q.size() < base + 4 && guard < 40) begin
      run_cycle();
      guard++;
    end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    wait_idle();
    chk("rr_count", acc_port_q.size() - base, 4);
    chk("rr_order", {acc_port_q[base], acc_port_q[base+1], acc_port_q[base+2], acc_port_q[base+3]}, 4'b0101);

    // Randomized mix of reads, writes and errors on both ports.
    base = n_acc; guard = 0;
    while (n_acc - base < 500 && guard < 6000) begin
      if (!p0_req_valid && $urandom_range(2, 0) == 0) begin
        new_req(p0_req_we, p0_req_addr, p0_req_wdata); p0_req_valid = 1'b1;
      end
      if (!p1_req_valid && $urandom_range(2, 0) == 0) begin
        new_req(p1_req_we, p1_req_addr, p1_req_wdata); p1_req_valid = 1'b1;
      end
      sz = acc_port_q.size();
      run_cycle();
      if (acc_port_q.size() != sz) begin
        if (acc_port_q[$]) p1_req_valid = 1'b0;
        else p0_req_valid = 1'b0;
      end
      guard++;
    end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    wait_idle();
    run_cycle();
    chk("random_progress", n_acc - base >= 500, 1);
    chk("rsp_per_accept", n_rsp, n_acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
